handshake_fifo_buffer: RTL and testbench

Elastic FIFO stage placed directly downstream of the handshake constant generators (e.g. a 33-bit constant source) and other dataflow producers. It decouples producer and consumer, cutting the combinational `ready` path between them, and sustains one token per cycle. Tokens leave in arrival order, with a fixed one-cycle minimum latency (no bypass).

---
 rtl/handshake_pkg.sv | 23 ++
 rtl/handshake_fifo_mem.sv | 35 +++
 rtl/handshake_fifo_buffer.sv | 85 ++++++++
 tb/tb_handshake_fifo_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared handshake dataflow package: common constants, clog2 helper and depth legality macro.

// True when n is a power of two and at least 2.
`define HS_IS_POW2(n) ((((n) >= 2) && ((((n) & ((n) - 1))) == 0)))

package handshake_pkg;

    localparam int unsigned HS_DEFAULT_DATA_WIDTH = 32;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Register-array token storage with one write port, one asynchronous read port and async clear.

module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned ADDR_W     = clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] storage [NUM_SLOTS];

    // Storage words: cleared on reset so discarded tokens never reappear on the read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                storage[i] <= '0;
            end
        end else if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    // Read mux straight from the flops; depth is a power of two so every address is in range.
    assign rd_data = storage[rd_addr];

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Elastic FIFO stage: registered valid/ready, in-order delivery, one-cycle minimum latency, no bypass.

module handshake_fifo_buffer
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int unsigned PTR_W = clog2(NUM_SLOTS);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Reject illegal depths at elaboration.
    generate
        if (!(`HS_IS_POW2(NUM_SLOTS))) begin : g_bad_depth
            $error("handshake_fifo_buffer: NUM_SLOTS must be a power of two and >= 2");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Transfers qualify only on registered ready/valid, so no input reaches an output combinationally.
    assign push = ins_valid && ins_ready;
    assign pop  = outs_valid && outs_ready;

    // Occupancy update: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and the registered handshake flags derived from next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ins_ready  <= 1'b0;
            outs_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            ins_ready  <= (count_next != CNT_W'(NUM_SLOTS));
            outs_valid <= (count_next != CNT_W'(0));
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (ins),
        .rd_addr (rd_ptr),
        .rd_data (outs)
    );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Self-checking bench for handshake_fifo_buffer against a queue-based reference model.

module tb_handshake_fifo_buffer;

    localparam int unsigned DW = 33;
    localparam int unsigned NS = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic [DW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of held tokens plus "accepting" flag that is false until the first edge after reset.
    logic [DW-1:0] q [$];
    bit            m_live;

    handshake_fifo_buffer #(
        .DATA_WIDTH (DW),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Advance one clock edge, updating the model from the inputs offered during this cycle.
    task automatic step();
        bit            do_push;
        bit            do_pop;
        logic [DW-1:0] d;
        do_push = rst && ins_valid && m_live && (q.size() < NS);
        do_pop  = rst && outs_ready && (q.size() != 0);
        d       = ins;
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
        m_live = rst;
        #1;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        q.delete();
        m_live = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        assert_reset();
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", outs_valid); end
        checks++; if (ins_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ins_ready); end
        checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outs: got %h want 0", outs); end
        step();
        rst = 1'b1;
        step();
        checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", ins_ready); end
        // Mid-stream reset with three held tokens.
        for (int i = 0; i < 3; i++) begin
            ins = DW'(32'hA0 + i); ins_valid = 1'b1;
            step();
        end
        ins_valid = 1'b0;
        checks++; if (outs_valid !== 1'b1 || outs !== DW'(32'hA0)) begin failures++; $display("FAIL midstream_head: got v=%b d=%h want v=1 d=a0", outs_valid, outs); end
        assert_reset();
        checks++; if (outs_valid !== 1'b0 || ins_ready !== 1'b0 || outs !== '0) begin failures++; $display("FAIL midstream_reset: got v=%b r=%b d=%h want 0/0/0", outs_valid, ins_ready, outs); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (ins_ready !== 1'b0) begin failures++; $display("FAIL release_before_edge: got %b want 0", ins_ready); end
        step();
        checks++; if (ins_ready !== 1'b1 || outs_valid !== 1'b0) begin failures++; $display("FAIL release_empty: got r=%b v=%b want r=1 v=0", ins_ready, outs_valid); end
    endtask

    task automatic test_single_latency();
        ins = 33'h0A9F18CCE; ins_valid = 1'b1; outs_ready = 1'b1;
        #1;
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL latency_push_cycle: got %b want 0", outs_valid); end
        step();
        ins_valid = 1'b0;
        checks++; if (outs_valid !== 1'b1 || outs !== 33'h0A9F18CCE) begin failures++; $display("FAIL latency_one_cycle: got v=%b d=%h want v=1 d=0a9f18cce", outs_valid, outs); end
        step();
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL latency_drained: got %b want 0", outs_valid); end
    endtask

    task automatic test_fill_backpressure();
        outs_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ins = DW'(i); ins_valid = 1'b1;
            checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d: got %b want 1", i, ins_ready); end
            step();
        end
        checks++; if (ins_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready: got %b want 0", ins_ready); end
        ins = DW'(5);
        step();
        step();
        ins_valid = 1'b0;
        checks++; if (ins_ready !== 1'b0 || outs !== DW'(1)) begin failures++; $display("FAIL fill_hold: got r=%b d=%h want r=0 d=1", ins_ready, outs); end
        outs_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (outs_valid !== 1'b1 || outs !== DW'(i)) begin failures++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, outs_valid, outs, DW'(i)); end
            step();
            if (i == 1) begin
                checks++; if (ins_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop: got %b want 1", ins_ready); end
            end
        end
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL fill_empty_after_drain: got %b want 0 (token 5 leaked)", outs_valid); end
        outs_ready = 1'b0;
    endtask

    task automatic test_full_with_pop();
        outs_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ins = DW'(32'h11 + i); ins_valid = 1'b1;
            step();
        end
        ins = DW'(9); ins_valid = 1'b1; outs_ready = 1'b1;
        step();
        ins_valid = 1'b0;
        checks++; if (ins_ready !== 1'b1 || outs !== DW'(32'h12)) begin failures++; $display("FAIL fullpop_step: got r=%b d=%h want r=1 d=12", ins_ready, outs); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (outs_valid !== 1'b1 || outs !== DW'(32'h11 + i)) begin failures++; $display("FAIL fullpop_drain_%0d: got v=%b d=%h want v=1 d=%h", i, outs_valid, outs, DW'(32'h11 + i)); end
            step();
        end
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL fullpop_refused: got v=%b want 0 (count was not 3)", outs_valid); end
        outs_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        ins_valid = 1'b1; outs_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ins = DW'(i);
            step();
            checks++; if (outs_valid !== 1'b1 || outs !== DW'(i)) begin failures++; $display("FAIL b2b_%0d: got v=%b d=%h want v=1 d=%h", i, outs_valid, outs, DW'(i)); end
        end
        ins_valid = 1'b0;
        step();
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b want 0", outs_valid); end
        outs_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] prev_outs;
        bit            prev_stall;
        int            bad;
        bad = 0;
        prev_stall = 1'b0;
        prev_outs  = '0;
        for (int c = 0; c < 10000; c++) begin
            ins        = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 32'($urandom)};
            ins_valid  = ($urandom_range(1, 0) == 1);
            outs_ready = ($urandom_range(1, 0) == 1);
            #1;
            checks++;
            if (outs_valid !== (q.size() != 0) || ins_ready !== (m_live && q.size() < NS)
                || (q.size() != 0 && outs !== q[0])) begin
                failures++;
                if (bad < 10) $display("FAIL random_cycle_%0d: got v=%b r=%b d=%h want v=%b r=%b d=%h", c, outs_valid, ins_ready, outs,
                                       q.size() != 0, m_live && q.size() < NS, (q.size() != 0) ? q[0] : '0);
                bad++;
            end
            if (prev_stall) begin
                checks++;
                if (outs_valid !== 1'b1 || outs !== prev_outs) begin
                    failures++;
                    if (bad < 10) $display("FAIL random_stable_%0d: got v=%b d=%h want v=1 d=%h", c, outs_valid, outs, prev_outs);
                    bad++;
                end
            end
            prev_stall = outs_valid && !outs_ready;
            prev_outs  = outs;
            step();
        end
        ins_valid = 1'b0; outs_ready = 1'b1;
        while (q.size() != 0) begin
            checks++;
            if (outs_valid !== 1'b1 || outs !== q[0]) begin
                failures++;
                $display("FAIL random_drain: got v=%b d=%h want v=1 d=%h", outs_valid, outs, q[0]);
            end
            step();
        end
        checks++; if (outs_valid !== 1'b0) begin failures++; $display("FAIL random_final_empty: got %b want 0", outs_valid); end
    endtask

    initial begin
        rst = 1'b1; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        m_live = 1'b0;
        #3;
        test_reset();
        test_single_latency();
        test_fill_backpressure();
        test_full_with_pop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
